// File: rtl/match_ctrl.sv
// match_ctrl: match sequencer for the two-player tank game.
// Runs the attract / countdown / play / round-over / match-over flow on the
// frame clock and drives both tanks' reset, respawn and loss inputs.
// Optional feature: define MATCH_TIMEOUT_EN to end a round as a draw after
// ROUND_TIME_FRAMES frames of play without a base win or elimination.
module match_ctrl #(
    parameter int LIVES              = 3,
    parameter int ROUNDS_TO_WIN      = 3,
    parameter int COUNTDOWN_FRAMES   = 180,
    parameter int ROUND_PAUSE_FRAMES = 120,
    parameter int ROUND_TIME_FRAMES  = 5400
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       hit1,
    input  logic       hit2,
    input  logic       win1,
    input  logic       win2,
    output logic       tank_rst,
    output logic       gotHit1,
    output logic       gotHit2,
    output logic       loss1,
    output logic       loss2,
    output logic       freeze,
    output logic [2:0] state,
    output logic [2:0] lives1,
    output logic [2:0] lives2,
    output logic [3:0] score1,
    output logic [3:0] score2
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        COUNTDOWN  = 3'd1,
        PLAY       = 3'd2,
        ROUND_OVER = 3'd3,
        MATCH_OVER = 3'd4
    } state_t;

    // One shared frame timer, wide enough for the longest interval it may count
    // (the round time limit is included so both builds use the same width).
    localparam int T_MAX0  = (COUNTDOWN_FRAMES > ROUND_PAUSE_FRAMES) ? COUNTDOWN_FRAMES
                                                                    : ROUND_PAUSE_FRAMES;
    localparam int T_MAX   = (T_MAX0 > ROUND_TIME_FRAMES) ? T_MAX0 : ROUND_TIME_FRAMES;
    localparam int TIMER_W = $clog2(T_MAX + 1);

    localparam logic [TIMER_W-1:0] CD_LAST    = TIMER_W'(COUNTDOWN_FRAMES - 1);
    localparam logic [TIMER_W-1:0] PAUSE_LAST = TIMER_W'(ROUND_PAUSE_FRAMES - 1);
`ifdef MATCH_TIMEOUT_EN
    localparam logic [TIMER_W-1:0] PLAY_LAST  = TIMER_W'(ROUND_TIME_FRAMES - 1);
`endif
    localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
    localparam logic [3:0]         SCORE_GOAL = 4'(ROUNDS_TO_WIN);

    state_t               fsm;
    logic [TIMER_W-1:0]   timer;
    logic                 start_q;

    logic                 start_now;
    logic                 start_rise;
    logic [2:0]           lives1_dec;
    logic [2:0]           lives2_dec;
    logic                 dead1;
    logic                 dead2;
    logic [3:0]           score1_inc;
    logic [3:0]           score2_inc;

    // The state register itself is the debug/HUD output.
    assign state = fsm;

    // START edge detect, floor-at-zero life decrements, saturating score increments.
    always_comb begin
        start_now  = (keycode == 8'h2C);
        start_rise = start_now & ~start_q;
        lives1_dec = (lives1 == 3'd0) ? 3'd0 : lives1 - 3'd1;
        lives2_dec = (lives2 == 3'd0) ? 3'd0 : lives2 - 3'd1;
        dead1      = hit2 & (lives1 <= 3'd1);
        dead2      = hit1 & (lives2 <= 3'd1);
        score1_inc = (score1 == 4'd15) ? 4'd15 : score1 + 4'd1;
        score2_inc = (score2 == 4'd15) ? 4'd15 : score2 + 4'd1;
    end

    // Match FSM with registered outputs, lives, scores and the frame timer.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            fsm      <= IDLE;
            tank_rst <= 1'b1;
            freeze   <= 1'b1;
            gotHit1  <= 1'b0;
            gotHit2  <= 1'b0;
            loss1    <= 1'b0;
            loss2    <= 1'b0;
            score1   <= 4'd0;
            score2   <= 4'd0;
            lives1   <= LIVES_INIT;
            lives2   <= LIVES_INIT;
            timer    <= '0;
            start_q  <= 1'b0;
        end else begin
            start_q <= start_now;
            gotHit1 <= 1'b0;
            gotHit2 <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start_rise) begin
                        fsm    <= COUNTDOWN;
                        score1 <= 4'd0;
                        score2 <= 4'd0;
                        lives1 <= LIVES_INIT;
                        lives2 <= LIVES_INIT;
                        timer  <= '0;
                    end
                end
                COUNTDOWN: begin
                    if (timer == CD_LAST) begin
                        fsm      <= PLAY;
                        tank_rst <= 1'b0;
                        freeze   <= 1'b0;
                        timer    <= '0;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                PLAY: begin
                    if (win1 | win2) begin
                        // Base destruction beats any hit in the same frame.
                        fsm    <= ROUND_OVER;
                        freeze <= 1'b1;
                        timer  <= '0;
                        if (win1 & ~win2) score1 <= score1_inc;
                        if (win2 & ~win1) score2 <= score2_inc;
                    end else begin
                        // Respawn pulses still go out on the eliminating hit.
                        gotHit1 <= hit2;
                        gotHit2 <= hit1;
                        if (hit2) lives1 <= lives1_dec;
                        if (hit1) lives2 <= lives2_dec;
                        if (dead1 | dead2) begin
                            fsm    <= ROUND_OVER;
                            freeze <= 1'b1;
                            timer  <= '0;
                            if (dead2 & ~dead1) score1 <= score1_inc;
                            if (dead1 & ~dead2) score2 <= score2_inc;
                        end
`ifdef MATCH_TIMEOUT_EN
                        else if (timer == PLAY_LAST) begin
                            fsm    <= ROUND_OVER;
                            freeze <= 1'b1;
                            timer  <= '0;
                        end else begin
                            timer <= timer + TIMER_W'(1);
                        end
`endif
                    end
                end
                ROUND_OVER: begin
                    if (timer == PAUSE_LAST) begin
                        timer <= '0;
                        if ((score1 == SCORE_GOAL) || (score2 == SCORE_GOAL)) begin
                            fsm   <= MATCH_OVER;
                            loss1 <= (score2 == SCORE_GOAL);
                            loss2 <= (score1 == SCORE_GOAL);
                        end else begin
                            fsm      <= COUNTDOWN;
                            tank_rst <= 1'b1;
                            lives1   <= LIVES_INIT;
                            lives2   <= LIVES_INIT;
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                MATCH_OVER: begin
                    if (start_rise) begin
                        fsm      <= IDLE;
                        tank_rst <= 1'b1;
                        loss1    <= 1'b0;
                        loss2    <= 1'b0;
                        score1   <= 4'd0;
                        score2   <= 4'd0;
                    end
                end
                default: begin
                    fsm      <= IDLE;
                    tank_rst <= 1'b1;
                    freeze   <= 1'b1;
                    timer    <= '0;
                end
            endcase
        end
    end

endmodule
